sobel_edge: RTL and testbench

Streaming 3x3 Sobel edge detector that sits directly downstream of the greyscale stage. It consumes the RGB565-packed grey stream and its per-pixel enable, and buffers two image lines to form a 3x3 window. It computes |Gx|+|Gy| on the 6-bit grey value and emits a binary edge map as RGB565 white/black pixels, one per input pixel, at fixed latency.

---
 rtl/sobel_edge.sv | 169 ++++++++++++++++
 tb/tb_sobel_edge.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector on the 6-bit grey (G) field of an RGB565 stream.
// Emits one white/black pixel per enabled input pixel with a fixed two-clock latency.
module sobel_edge #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int THRESH = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Din,
    input  logic        dataEn,
    output logic [15:0] Dout,
    output logic        outEn,
    output logic        frameDone
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [8:0]    THR      = 9'(THRESH);

    // Weighted column/row sum a + 2b + c of three grey samples (max 252).
    function automatic logic [7:0] wsum(input logic [5:0] a, input logic [5:0] b,
                                        input logic [5:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Absolute value of the 9-bit signed difference of two partial sums.
    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d[8]) begin
            return 8'(-d);
        end else begin
            return 8'(d);
        end
    endfunction

    // Only the G field carries the grey value; the rest of the pixel is ignored.
    logic unused_din_s;
    assign unused_din_s = ^{Din[15:11], Din[4:0]};

    logic [5:0]          grey_q, grey_d;
    logic                en_q, en_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [2:0][2:0][5:0] win_q, win_d;
    logic                v1_q, v1_d;
    logic                border_q, border_d;
    logic                last_q, last_d;
    logic [15:0]         dout_q, dout_d;
    logic                oen_q, oen_d;
    logic                fd_q, fd_d;

    logic [5:0] line0_mem [IMG_W];
    logic [5:0] line1_mem [IMG_W];
    logic [5:0] rd0_s, rd1_s;
    logic [7:0] gx_s, gy_s;
    logic [8:0] mag_s;

    assign rd0_s = line0_mem[col_q];
    assign rd1_s = line1_mem[col_q];

    // Input capture stage.
    always_comb begin
        grey_d = grey_q;
        en_d   = dataEn;
        if (dataEn) begin
            grey_d = Din[10:5];
        end else begin
            grey_d = grey_q;
        end
    end

    // Position counters, window shift and border/last flags for the captured pixel.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        win_d    = win_q;
        v1_d     = 1'b0;
        border_d = border_q;
        last_d   = last_q;
        if (en_q) begin
            v1_d     = 1'b1;
            border_d = (row_q < RW'(2)) || (col_q < CW'(2));
            last_d   = (col_q == COL_LAST) && (row_q == ROW_LAST);
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = rd1_s;
            win_d[1][2] = rd0_s;
            win_d[2][2] = grey_q;
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
        end else begin
            v1_d = 1'b0;
        end
    end

    // Gradient magnitude, threshold and border mask.
    always_comb begin
        gx_s   = absdiff(wsum(win_q[0][2], win_q[1][2], win_q[2][2]),
                         wsum(win_q[0][0], win_q[1][0], win_q[2][0]));
        gy_s   = absdiff(wsum(win_q[2][0], win_q[2][1], win_q[2][2]),
                         wsum(win_q[0][0], win_q[0][1], win_q[0][2]));
        mag_s  = {1'b0, gx_s} + {1'b0, gy_s};
        oen_d  = v1_q;
        fd_d   = v1_q && last_q;
        dout_d = 16'h0000;
        if (v1_q && !border_q && (mag_s > THR)) begin
            dout_d = 16'hFFFF;
        end else begin
            dout_d = 16'h0000;
        end
    end

    // Pipeline and position state; rst drops every in-flight pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            grey_q   <= 6'd0;
            en_q     <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= '0;
            v1_q     <= 1'b0;
            border_q <= 1'b1;
            last_q   <= 1'b0;
            dout_q   <= 16'h0000;
            oen_q    <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            grey_q   <= grey_d;
            en_q     <= en_d;
            col_q    <= col_d;
            row_q    <= row_d;
            win_q    <= win_d;
            v1_q     <= v1_d;
            border_q <= border_d;
            last_q   <= last_d;
            dout_q   <= dout_d;
            oen_q    <= oen_d;
            fd_q     <= fd_d;
        end
    end

    // Line buffers: read-before-write at col, never reset (border mask hides stale data).
    always_ff @(posedge clk) begin
        if (en_q && !rst) begin
            line1_mem[col_q] <= rd0_s;
            line0_mem[col_q] <= grey_q;
        end
    end

    assign Dout      = dout_q;
    assign outEn     = oen_q;
    assign frameDone = fd_q;

endmodule

// File: tb/tb_sobel_edge.sv
// Scoreboard bench for sobel_edge: three instances (THRESH 48/252/251) share one stimulus
// stream; a negedge monitor pops expected pixels whenever outEn is seen.
module tb_sobel_edge;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dataEn;
    logic [15:0] Din;
    logic [15:0] dout0, dout1, dout2;
    logic        oen0, oen1, oen2;
    logic        fd0, fd1, fd2;

    always #5 clk = ~clk;

    sobel_edge #(.IMG_W(W), .IMG_H(H), .THRESH(48)) dut48 (
        .clk(clk), .rst(rst), .Din(Din), .dataEn(dataEn),
        .Dout(dout0), .outEn(oen0), .frameDone(fd0));
    sobel_edge #(.IMG_W(W), .IMG_H(H), .THRESH(252)) dut252 (
        .clk(clk), .rst(rst), .Din(Din), .dataEn(dataEn),
        .Dout(dout1), .outEn(oen1), .frameDone(fd1));
    sobel_edge #(.IMG_W(W), .IMG_H(H), .THRESH(251)) dut251 (
        .clk(clk), .rst(rst), .Din(Din), .dataEn(dataEn),
        .Dout(dout2), .outEn(oen2), .frameDone(fd2));

    typedef struct {
        logic [15:0] e48;
        logic [15:0] e252;
        logic [15:0] e251;
        logic        fd;
        int          cyc;
        logic        drop;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc_cnt = 0;
    int   rd_idx  = 0;
    int   errors  = 0;
    int   checks  = 0;
    logic mon_en  = 1'b0;
    logic done    = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pixel(input logic [15:0] px, input logic is_edge, input logic last);
        exp_t e;
        e.e48  = is_edge ? 16'hFFFF : 16'h0000;
        e.e252 = 16'h0000;
        e.e251 = is_edge ? 16'hFFFF : 16'h0000;
        e.fd   = last;
        e.cyc  = cyc_cnt + 1;
        e.drop = 1'b0;
        sb_q.push_back(e);
        Din    = px;
        dataEn = 1'b1;
        step_cycle();
        dataEn = 1'b0;
        Din    = 16'hA5A5;
    endtask

    // Step frame: cols 0-3 black, 4-7 white; edges (mag 252) at rows 2-3, cols 4 and 5.
    task automatic send_frame(input bit step, input bit gapped, input int npix);
        for (int i = 0; i < npix; i++) begin
            int r;
            int c;
            r = i / W;
            c = i % W;
            push_pixel(step ? ((c >= 4) ? 16'hFFFF : 16'h0000) : 16'h7BEF,
                       step && (r >= 2) && (c == 4 || c == 5),
                       i == W * H - 1);
            if (gapped) step_cycle();
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (rd_idx < sb_q.size() && sb_q[rd_idx].drop) rd_idx++;
            if (oen0) begin
                if (rd_idx >= sb_q.size()) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_outEn: outEn=1 at cycle %0d, required no output",
                             cyc_cnt);
                end else begin
                    mon_e = sb_q[rd_idx];
                    rd_idx++;
                    chk("latency", 64'(cyc_cnt), 64'(mon_e.cyc + 2));
                    chk("dout_t48", 64'(dout0), 64'(mon_e.e48));
                    chk("dout_t252", 64'(dout1), 64'(mon_e.e252));
                    chk("dout_t251", 64'(dout2), 64'(mon_e.e251));
                    chk("frameDone", 64'({fd0, fd1, fd2}), mon_e.fd ? 64'd7 : 64'd0);
                    chk("outEn_peers", 64'({oen1, oen2}), 64'd3);
                end
            end else begin
                chk("idle_outEn", 64'({oen1, oen2}), 64'd0);
                chk("idle_Dout", 64'({dout0, dout1, dout2}), 64'd0);
                chk("idle_frameDone", 64'({fd0, fd1, fd2}), 64'd0);
                if (rd_idx < sb_q.size() && cyc_cnt > sb_q[rd_idx].cyc + 2) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_output: no outEn by cycle %0d, required at cycle %0d",
                             cyc_cnt, sb_q[rd_idx].cyc + 2);
                    rd_idx++;
                end
            end
            if (done) begin
                chk("drained", 64'(sb_q.size() - rd_idx), 64'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, required completion within 100000 time units");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        dataEn = 1'b1;
        Din    = 16'hFFFF;
        step_cycle();
        mon_en = 1'b1;
        step_cycle();
        step_cycle();
        rst    = 1'b0;
        dataEn = 1'b0;
        Din    = 16'h0000;
        repeat (2) step_cycle();

        send_frame(1'b0, 1'b0, W * H);
        send_frame(1'b1, 1'b0, W * H);
        send_frame(1'b1, 1'b1, W * H);
        send_frame(1'b0, 1'b0, W * H);

        send_frame(1'b1, 1'b0, 13);
        sb_q[sb_q.size() - 1].drop = 1'b1;
        sb_q[sb_q.size() - 2].drop = 1'b1;
        rst    = 1'b1;
        dataEn = 1'b1;
        Din    = 16'hFFFF;
        step_cycle();
        rst    = 1'b0;
        dataEn = 1'b0;
        send_frame(1'b1, 1'b0, W * H);

        repeat (8) step_cycle();
        done = 1'b1;
    end

endmodule
